// File: rtl/i2c_cfg_sequencer.sv
// Purpose: walks a fixed table of codec configuration words out through an I2C byte engine, with retry and timeout.
// Latency: o_req rises one cycle after an accepted i_start; transfers are separated by GAP_CYCLES idle cycles.
// Backpressure: one transfer in flight; the next o_req waits for i_done (or timeout) plus the gap.
module i2c_cfg_sequencer #(
   parameter int NUM_CMDS       = 11,
   parameter int MAX_RETRY      = 3,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_finished,
   output logic        o_error,
   output logic        o_req,
   output logic [6:0]  o_dev_addr,
   output logic [15:0] o_word,
   input  logic        i_done,
   input  logic        i_nack,
   output logic [3:0]  o_cmd_idx
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [3:0] LAST_IDX = 4'(NUM_CMDS - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERROR} state_t;

   state_t        state;
   logic [RW-1:0] retry_cnt;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          last_ok;    // outcome of the transfer that led into GAP
   logic [3:0]    issue_idx;  // index to send when GAP expires

   // Codec register/data words, sent in index order.
   function automatic logic [15:0] cfg_word(input logic [3:0] idx);
      case (idx)
         4'd0:    cfg_word = 16'h1E00;
         4'd1:    cfg_word = 16'h0097;
         4'd2:    cfg_word = 16'h0297;
         4'd3:    cfg_word = 16'h0479;
         4'd4:    cfg_word = 16'h0679;
         4'd5:    cfg_word = 16'h0815;
         4'd6:    cfg_word = 16'h0A00;
         4'd7:    cfg_word = 16'h0C00;
         4'd8:    cfg_word = 16'h0E42;
         4'd9:    cfg_word = 16'h1019;
         4'd10:   cfg_word = 16'h1201;
         default: cfg_word = 16'h0000;
      endcase
   endfunction

   assign o_dev_addr = 7'h1A;
   assign issue_idx  = last_ok ? (o_cmd_idx + 4'd1) : o_cmd_idx;

   // Sequencer FSM; every output is a register updated on the transition that changes it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_req      <= 1'b0;
         o_busy     <= 1'b0;
         o_finished <= 1'b0;
         o_error    <= 1'b0;
         o_cmd_idx  <= 4'd0;
         o_word     <= 16'h0000;
         retry_cnt  <= '0;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         last_ok    <= 1'b0;
      end else begin
         o_req <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (i_start) begin
                  state      <= ISSUE;
                  o_finished <= 1'b0;
                  o_error    <= 1'b0;
                  o_cmd_idx  <= 4'd0;
                  retry_cnt  <= '0;
                  o_req      <= 1'b1;
                  o_busy     <= 1'b1;
                  o_word     <= cfg_word(4'd0);
               end
            end
            ISSUE: begin
               state  <= WAIT;
               to_cnt <= '0;
            end
            WAIT: begin
               if (i_done && !i_nack) begin
                  retry_cnt <= '0;
                  last_ok   <= 1'b1;
                  gap_cnt   <= '0;
                  to_cnt    <= '0;
                  state     <= GAP;
               end else if (i_done || (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                  // A silent engine is treated exactly like a NACK.
                  to_cnt <= '0;
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + RW'(1);
                     last_ok   <= 1'b0;
                     gap_cnt   <= '0;
                     state     <= GAP;
                  end else begin
                     state   <= ERROR;
                     o_error <= 1'b1;
                     o_busy  <= 1'b0;
                  end
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  gap_cnt <= '0;
                  if (last_ok && (o_cmd_idx == LAST_IDX)) begin
                     state      <= DONE;
                     o_finished <= 1'b1;
                     o_busy     <= 1'b0;
                  end else begin
                     state     <= ISSUE;
                     o_cmd_idx <= issue_idx;
                     o_word    <= cfg_word(issue_idx);
                     o_req     <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
